// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus for the program loader.
// The host/test side takes the master modport, the loader takes the slave modport.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_type;
  logic [1:0]        in_func;
  logic              in_imm;
  logic              in_vector;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [15:0]       in_rs2_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_type, in_func, in_imm, in_vector, in_rd, in_rs1, in_rs2_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_type, in_func, in_imm, in_vector, in_rd, in_rs1, in_rs2_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words and streams them into
// instruction memory, holding the CPU until a program has loaded cleanly.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]       o_word_count,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERROR} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  state_t            r_state;
  state_t            w_nstate;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_last;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_err_code;

  logic              w_fire;
  logic              w_legal;
  logic              w_reg_only;
  logic [31:0]       w_enc;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_full;

  assign w_fire    = (r_state == S_LOAD) && bus.in_valid;
  assign w_cnt_nxt = r_count + 1'b1;
  assign w_full    = (w_cnt_nxt == MAX_CNT);

  // Only the field combinations the control unit actually decodes are accepted.
  always_comb begin
    w_legal = 1'b0;
    case (bus.in_type)
      2'b00: w_legal = (bus.in_func == 2'b00);
      2'b01: w_legal = !bus.in_func[1];
      2'b10: begin
        if (bus.in_imm) w_legal = !bus.in_vector;
        else            w_legal = bus.in_vector ? (bus.in_func != 2'b11) : (bus.in_func == 2'b00);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Register-form type 10 carries only rs2 in the low field; the rest is zeroed.
  assign w_reg_only = (bus.in_type == 2'b10) && !bus.in_imm;
  assign w_enc = {bus.in_type, bus.in_func, bus.in_imm, bus.in_vector, bus.in_rd, bus.in_rs1,
                  w_reg_only ? {11'b0, bus.in_rs2_imm[4:0]} : bus.in_rs2_imm};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (i_start) w_nstate = S_LOAD;
      S_LOAD:  if (w_fire) w_nstate = w_legal ? S_WRITE : S_ERROR;
      S_WRITE: w_nstate = r_last ? S_DONE : (w_full ? S_ERROR : S_LOAD);
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.imem_we  = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    o_cpu_hold   = 1'b1;
    case (r_state)
      S_LOAD:  bus.in_ready = 1'b1;
      S_WRITE: bus.imem_we  = 1'b1;
      S_DONE:  begin o_done = 1'b1; o_cpu_hold = 1'b0; end
      S_ERROR: o_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_last     <= 1'b0;
      r_count    <= '0;
      r_err_code <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_err_code <= 2'b00;
          end
        end
        S_LOAD: begin
          if (w_fire) begin
            if (w_legal) begin
              r_wdata <= w_enc;
              r_last  <= bus.in_last;
            end else begin
              r_err_code <= 2'b01;
            end
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + 1'b1;
          r_count <= w_cnt_nxt;
          // Capacity exhausted without in_last: keep the final write, flag overflow.
          if (!r_last && w_full) r_err_code <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign o_word_count   = r_count;
  assign o_err_code     = r_err_code;

endmodule
